// File: rtl/enc_period_quad_sync.sv
// Quadrature encoder period meter: synchronises A/B, decodes direction and reports
// max(latched period of the last edge, running count toward the next expected edge).
module enc_period_quad_sync #(
  parameter  int CNT_W       = 26,
  parameter  int SYNC_STAGES = 2,
  localparam int PER_W       = CNT_W + 6
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             err_clr,
  output logic             dir,
  output logic             edge_stb,
  output logic [PER_W-1:0] period,
  output logic             quad_err
);

  // last-edge state | meaning
  // E_AUP           | A rose (also the reset state)
  // E_ADN           | A fell
  // E_BUP           | B rose
  // E_BDN           | B fell
  typedef enum logic [1:0] {E_AUP = 2'b00, E_ADN = 2'b01, E_BUP = 2'b10, E_BDN = 2'b11} edge_e;

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_prev_q, b_prev_q;
  logic                   a_s, b_s, ea, eb;

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [CNT_W-1:0] lat_q [4];
  logic [CNT_W-1:0] lat_d [4];
  logic [3:0]       armed_q, armed_d;
  edge_e            last_q, last_d, e_new;
  logic             dir_q, dir_d, dir_new;
  logic             chg_q, chg_d;
  logic             stb_q, stb_d;
  logic             qerr_q, qerr_d;
  logic [PER_W-1:0] period_q, period_d;

  edge_e            nxt, rep;
  logic [CNT_W-1:0] run_v, lat_v, val;
  logic             src;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic edge_e next_edge(input edge_e l, input logic d);
    edge_e n;
    case (l)
      E_AUP:   n = d ? E_BDN : E_BUP;
      E_BUP:   n = d ? E_AUP : E_ADN;
      E_ADN:   n = d ? E_BUP : E_BDN;
      default: n = d ? E_ADN : E_AUP;
    endcase
    return n;
  endfunction

  assign a_s = a_sync_q[SYNC_STAGES-1];
  assign b_s = b_sync_q[SYNC_STAGES-1];
  assign ea  = a_s ^ a_prev_q;
  assign eb  = b_s ^ b_prev_q;

  always_comb begin
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    armed_d = armed_q;
    last_d  = last_q;
    dir_d   = dir_q;
    chg_d   = chg_q;
    stb_d   = 1'b0;
    qerr_d  = qerr_q;
    e_new   = E_AUP;
    dir_new = dir_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = sat_inc(cnt_q[i]);

    if (ea && eb)   qerr_d = 1'b1;
    else if (err_clr) qerr_d = 1'b0;

    if (ea ^ eb) begin
      if (ea) begin
        e_new   = a_s ? E_AUP : E_ADN;
        dir_new = (a_s == b_s);
      end else begin
        e_new   = b_s ? E_BUP : E_BDN;
        dir_new = (b_s != a_s);
      end
      stb_d  = 1'b1;
      last_d = e_new;
      dir_d  = dir_new;
      // A reversal invalidates every stored period, including this edge's own.
      if (dir_new != dir_q) begin
        armed_d = '0;
        chg_d   = 1'b1;
      end
      if (armed_d[e_new]) lat_d[e_new] = sat_inc(cnt_q[e_new]);
      armed_d[e_new] = 1'b1;
      cnt_d[e_new]   = '0;
      if (&armed_d) chg_d = 1'b0;
    end
  end

  always_comb begin
    nxt   = next_edge(last_q, dir_q);
    run_v = cnt_q[nxt];
    lat_v = lat_q[last_q];
    if (!armed_q[last_q] || run_v >= lat_v) begin
      val = run_v;
      src = 1'b0;
      rep = nxt;
    end else begin
      val = lat_v;
      src = 1'b1;
      rep = last_q;
    end
    period_d = {src, dir_q, chg_q, rep, &val, val};
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
        lat_q[i] <= '0;
      end
      armed_q  <= '0;
      last_q   <= E_AUP;
      dir_q    <= 1'b0;
      chg_q    <= 1'b0;
      stb_q    <= 1'b0;
      qerr_q   <= 1'b0;
      period_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b};
      a_prev_q <= a_s;
      b_prev_q <= b_s;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      armed_q  <= armed_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      chg_q    <= chg_d;
      stb_q    <= stb_d;
      qerr_q   <= qerr_d;
      period_q <= period_d;
    end
  end

  assign dir      = dir_q;
  assign edge_stb = stb_q;
  assign period   = period_q;
  assign quad_err = qerr_q;

endmodule
